tpu_tile_sequencer: RTL and testbench
=====================================

Name: tpu_tile_sequencer

Overview:
Parametrised, multi-tile successor to the single-shot TPU control path. It runs a job of `num_tiles` matrix tiles back-to-back. For each tile it generates SRAM read addresses for NUM_BANKS weight/data banks, drives the systolic ALU timing (alu_start, cycle_num, matrix_index), and writes result rows round-robin into NUM_OUT_BANKS output SRAMs under a valid/ready handshake. It sits between the host start/done interface and the systolic array/quantize/SRAM datapath, which is not carried through this block.

Parameters:
- ARRAY_SIZE, 32, systolic array dimension; rows written per tile.
- NUM_BANKS, 8, number of read SRAM banks (weights and data each).
- ADDR_WIDTH, 10, read address width.
- NUM_OUT_BANKS, 3, number of output SRAM banks (≥1).
- OUT_ADDR_WIDTH, 6, output write address width.
- TILE_CNT_WIDTH, 8, width of num_tiles.
- CYC_WIDTH, 9, width of cycle_num.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- tpu_start  in  1  job start; sampled only in IDLE.
- num_tiles  in  TILE_CNT_WIDTH  tiles in job; latched on start.
- tile_len  in  ADDR_WIDTH  feed cycles per tile; latched on start.
- sram_raddr_w  out  NUM_BANKS*ADDR_WIDTH  weight read addresses, bank b at slice b.
- sram_raddr_d  out  NUM_BANKS*ADDR_WIDTH  data read addresses, same layout.
- alu_start  out  1  systolic array enable.
- cycle_num  out  CYC_WIDTH  cycle within current tile.
- matrix_index  out  $clog2(ARRAY_SIZE)  result row being written.
- wr_valid  out  1  result row write request.
- wr_ready  in  1  write sink accepts the row.
- sram_write_enable  out  NUM_OUT_BANKS  one-hot bank write enable; equals wr_valid&wr_ready gated to the selected bank.
- sram_waddr  out  OUT_ADDR_WIDTH  write address.
- busy  out  1  high in any state other than IDLE.
- tpu_done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered except sram_write_enable, which is combinational from state and wr_ready.
- FSM states: IDLE, FEED, DRAIN, WRITE, DONE.
- Reset: state=IDLE. All addresses, cycle_num, matrix_index, tile index, round counter, bank select are 0. alu_start, wr_valid, busy, tpu_done are 0.
- IDLE:
  - tpu_start=1 with num_tiles≠0 and tile_len≠0: latch both inputs, tile_idx=0, bank=0, round=0, go to FEED next cycle.
  - tpu_start=1 with either input =0: go to DONE (tpu_done one cycle later, no reads or writes).
- FEED: lasts tile_len cycles.
  - cycle_num counts 0..tile_len-1.
  - Every bank's raddr (w and d) = tile_idx*tile_len + cycle_num, truncated to ADDR_WIDTH; address wrap is silent.
  - alu_start=1.
- DRAIN: lasts 2*ARRAY_SIZE-1 cycles.
  - cycle_num continues counting; alu_start=1.
  - Read addresses hold their last value.
- WRITE:
  - alu_start=0, wr_valid=1, matrix_index = row (0..ARRAY_SIZE-1).
  - sram_waddr = round*ARRAY_SIZE + row, truncated to OUT_ADDR_WIDTH.
  - A row advances only on wr_valid&wr_ready. wr_ready=0 holds row, matrix_index, sram_waddr and wr_valid stable.
  - After the last row is accepted:
    - bank increments, wrapping at NUM_OUT_BANKS-1 to 0; round increments on each wrap.
    - If tile_idx==num_tiles-1, go to DONE. Otherwise tile_idx++, cycle_num=0, go to FEED.
- DONE: tpu_done=1 for exactly one cycle, then IDLE; busy drops in IDLE.
- Latency: single tile, L=tile_len, A=ARRAY_SIZE, wr_ready held high, start at cycle T → tpu_done at T+L+3A.
- tpu_start while busy is ignored. num_tiles/tile_len changes after the start cycle have no effect.
- srst mid-job returns to reset values the next cycle. No write enable is issued in the reset cycle.

Optional Feature:
- Macro TPU_TILE_SEQ_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit) and output `aborted` (1 bit).
  - abort=1 in FEED, DRAIN or WRITE forces DONE next cycle, with alu_start=0 and wr_valid=0 that cycle.
  - tpu_done pulses with aborted=1 the same cycle. aborted is 0 on normal completion and resets to 0.
  - abort is ignored in IDLE and DONE.
- Not defined: no ports are added; the job always runs to completion.

Test Plan:
- ARRAY_SIZE=4, NUM_OUT_BANKS=3, num_tiles=1, tile_len=4, wr_ready=1, start at T:
  - raddr 0,1,2,3 at T+1..T+4.
  - bank0 writes waddr 0..3 at T+12..T+15.
  - tpu_done at T+16 only.
- Same config, num_tiles=4, tile_len=4:
  - read addresses 0..15 over four FEEDs.
  - writes go to banks 0,1,2,0; waddr 0..3, 0..3, 0..3, 4..7.
  - tpu_done at T+61.
- Backpressure: wr_ready low for 3 cycles at row 2 → matrix_index=2 and waddr=2 held, no sram_write_enable; tpu_done delayed by exactly 3 cycles.
- Start with num_tiles=0 → tpu_done at T+2, busy high only at T+1, no alu_start or writes. A second tpu_start while busy is ignored.
- srst asserted mid-DRAIN → next cycle busy=0, alu_start=0, all addresses 0. A new start runs normally from tile 0.
- With TPU_TILE_SEQ_ABORT_EN: abort during WRITE row 1 of tile 0 → next cycle tpu_done=1, aborted=1, no further write enables.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer
//
// Control sequencer for a multi-tile systolic matrix job. A job of
// num_tiles tiles is run back-to-back. Each tile streams tile_len feed
// cycles of read addresses to every weight/data bank. It then drains the
// systolic array for 2*ARRAY_SIZE-1 cycles. Finally it writes ARRAY_SIZE
// result rows, round-robin across the output banks, under valid/ready.
//
// Ports
//   clk, srst          clock, synchronous active-high reset
//   tpu_start          job start (only looked at while idle)
//   num_tiles          tiles in the job, captured on start
//   tile_len           feed cycles per tile, captured on start
//   sram_raddr_w/_d    per-bank read addresses (bank b in slice b)
//   alu_start          systolic array enable
//   cycle_num          cycle index within the current tile
//   matrix_index       result row currently offered for writing
//   wr_valid/wr_ready  result row write handshake
//   sram_write_enable  one-hot output bank strobe (combinational)
//   sram_waddr         output row address
//   busy               high whenever the sequencer is not idle
//   tpu_done           one-cycle completion pulse
//
// Optional build macro TPU_TILE_SEQ_ABORT_EN adds input abort and output
// aborted. With it, a running job can be cut short into the done pulse.

module tpu_tile_sequencer #(
    parameter int ARRAY_SIZE     = 32,
    parameter int NUM_BANKS      = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_OUT_BANKS  = 3,
    parameter int OUT_ADDR_WIDTH = 6,
    parameter int TILE_CNT_WIDTH = 8,
    parameter int CYC_WIDTH      = 9
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            tpu_start,
    input  logic [TILE_CNT_WIDTH-1:0]       num_tiles,
    input  logic [ADDR_WIDTH-1:0]           tile_len,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] sram_raddr_w,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] sram_raddr_d,
    output logic                            alu_start,
    output logic [CYC_WIDTH-1:0]            cycle_num,
    output logic [$clog2(ARRAY_SIZE)-1:0]   matrix_index,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [NUM_OUT_BANKS-1:0]        sram_write_enable,
    output logic [OUT_ADDR_WIDTH-1:0]       sram_waddr,
    output logic                            busy,
    output logic                            tpu_done
`ifdef TPU_TILE_SEQ_ABORT_EN
    ,
    input  logic                            abort,
    output logic                            aborted
`endif
);

    localparam int ROW_W   = $clog2(ARRAY_SIZE);
    localparam int BANK_W  = (NUM_OUT_BANKS > 1) ? $clog2(NUM_OUT_BANKS) : 1;
    localparam int DRAIN_W = $clog2(2 * ARRAY_SIZE);
    localparam int CNT_W   = (ADDR_WIDTH > DRAIN_W) ? ADDR_WIDTH : DRAIN_W;

    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(2 * ARRAY_SIZE - 2);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ARRAY_SIZE - 1);
    localparam logic [BANK_W-1:0] BANK_LAST  = BANK_W'(NUM_OUT_BANKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [TILE_CNT_WIDTH-1:0] num_tiles_q, num_tiles_d;
    logic [ADDR_WIDTH-1:0]     tile_len_q, tile_len_d;
    logic [TILE_CNT_WIDTH-1:0] tile_idx_q, tile_idx_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CYC_WIDTH-1:0]      cycle_num_q, cycle_num_d;
    logic [ADDR_WIDTH-1:0]     raddr_q, raddr_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [OUT_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [BANK_W-1:0]         bank_q, bank_d;
    logic [OUT_ADDR_WIDTH-1:0] round_q, round_d;
    logic                      alu_start_q, alu_start_d;
    logic                      wr_valid_q, wr_valid_d;
    logic                      busy_q, busy_d;
    logic                      tpu_done_q, tpu_done_d;
    logic                      empty_q, empty_d;
`ifdef TPU_TILE_SEQ_ABORT_EN
    logic                      aborted_q, aborted_d;
`endif

    logic [CNT_W-1:0] feed_last;
    logic             row_accept;
    logic             last_tile;

    assign feed_last  = CNT_W'(tile_len_q) - CNT_W'(1);
    assign row_accept = wr_valid_q && wr_ready;
    assign last_tile  = (tile_idx_q == num_tiles_q - TILE_CNT_WIDTH'(1));

    // Next-state and next-output logic. Every registered output is computed
    // here from the state being entered, so it is valid in the first cycle
    // of that state. An empty job (zero tiles or zero length) passes
    // through DONE for its single busy cycle. It raises tpu_done on the
    // way back to IDLE, which the empty_q flag remembers.
    always_comb begin
        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        tile_len_d  = tile_len_q;
        tile_idx_d  = tile_idx_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        cycle_num_d = cycle_num_q;
        raddr_d     = raddr_q;
        row_d       = row_q;
        waddr_d     = waddr_q;
        bank_d      = bank_q;
        round_d     = round_q;
        empty_d     = empty_q;
        alu_start_d = 1'b0;
        wr_valid_d  = 1'b0;
        tpu_done_d  = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (tpu_start) begin
                    if (num_tiles != '0 && tile_len != '0) begin
                        state_d     = FEED;
                        num_tiles_d = num_tiles;
                        tile_len_d  = tile_len;
                        tile_idx_d  = '0;
                        bank_d      = '0;
                        round_d     = '0;
                        base_d      = '0;
                        cnt_d       = '0;
                        cycle_num_d = '0;
                        raddr_d     = '0;
                        alu_start_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        empty_d = 1'b1;
                    end
                end
            end

            FEED: begin
                alu_start_d = 1'b1;
                cycle_num_d = cycle_num_q + CYC_WIDTH'(1);
                if (cnt_q == feed_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    raddr_d = base_q + cnt_d[ADDR_WIDTH-1:0];
                end
            end

            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d    = WRITE;
                    wr_valid_d = 1'b1;
                    row_d      = '0;
                    waddr_d    = OUT_ADDR_WIDTH'(round_q * ARRAY_SIZE);
                end else begin
                    alu_start_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    cycle_num_d = cycle_num_q + CYC_WIDTH'(1);
                end
            end

            WRITE: begin
                wr_valid_d = 1'b1;
                if (row_accept) begin
                    if (row_q == ROW_LAST) begin
                        wr_valid_d = 1'b0;
                        if (bank_q == BANK_LAST) begin
                            bank_d  = '0;
                            round_d = round_q + OUT_ADDR_WIDTH'(1);
                        end else begin
                            bank_d = bank_q + BANK_W'(1);
                        end
                        if (last_tile) begin
                            state_d    = DONE;
                            tpu_done_d = 1'b1;
                        end else begin
                            state_d     = FEED;
                            tile_idx_d  = tile_idx_q + TILE_CNT_WIDTH'(1);
                            base_d      = base_q + tile_len_q;
                            raddr_d     = base_d;
                            cnt_d       = '0;
                            cycle_num_d = '0;
                            alu_start_d = 1'b1;
                        end
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        waddr_d = waddr_q + OUT_ADDR_WIDTH'(1);
                    end
                end
            end

            DONE: begin
                state_d    = IDLE;
                tpu_done_d = empty_q;
                empty_d    = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef TPU_TILE_SEQ_ABORT_EN
        // An abort cuts straight to the done pulse from any active phase,
        // quietening the array and the write port in the same step.
        aborted_d = 1'b0;
        if (abort && (state_q == FEED || state_q == DRAIN || state_q == WRITE)) begin
            state_d     = DONE;
            alu_start_d = 1'b0;
            wr_valid_d  = 1'b0;
            tpu_done_d  = 1'b1;
            aborted_d   = 1'b1;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= IDLE;
            num_tiles_q <= '0;
            tile_len_q  <= '0;
            tile_idx_q  <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            cycle_num_q <= '0;
            raddr_q     <= '0;
            row_q       <= '0;
            waddr_q     <= '0;
            bank_q      <= '0;
            round_q     <= '0;
            alu_start_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            tpu_done_q  <= 1'b0;
            empty_q     <= 1'b0;
`ifdef TPU_TILE_SEQ_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            tile_len_q  <= tile_len_d;
            tile_idx_q  <= tile_idx_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            cycle_num_q <= cycle_num_d;
            raddr_q     <= raddr_d;
            row_q       <= row_d;
            waddr_q     <= waddr_d;
            bank_q      <= bank_d;
            round_q     <= round_d;
            alu_start_q <= alu_start_d;
            wr_valid_q  <= wr_valid_d;
            busy_q      <= busy_d;
            tpu_done_q  <= tpu_done_d;
            empty_q     <= empty_d;
`ifdef TPU_TILE_SEQ_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    // The write strobe follows the handshake directly. It is held off
    // while reset is asserted, so a reset cycle never commits a row.
    always_comb begin
        sram_write_enable = '0;
        if (!srst && state_q == WRITE && row_accept) begin
            sram_write_enable[bank_q] = 1'b1;
        end
    end

    // All banks read the same tile row, so one address register fans out.
    assign sram_raddr_w = {NUM_BANKS{raddr_q}};
    assign sram_raddr_d = {NUM_BANKS{raddr_q}};
    assign alu_start    = alu_start_q;
    assign cycle_num    = cycle_num_q;
    assign matrix_index = row_q;
    assign wr_valid     = wr_valid_q;
    assign sram_waddr   = waddr_q;
    assign busy         = busy_q;
    assign tpu_done     = tpu_done_q;
`ifdef TPU_TILE_SEQ_ABORT_EN
    assign aborted      = aborted_q;
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb_tpu_tile_sequencer
//
// Bench for tpu_tile_sequencer with ARRAY_SIZE=4 and three output banks.
// Each job is run cycle by cycle while the read stream, the write stream,
// the stall count and the done timing are collected. The collected data
// is then compared with sequences built from the job parameters.

module tb_tpu_tile_sequencer;

    localparam int A   = 4;
    localparam int NB  = 8;
    localparam int AW  = 10;
    localparam int NOB = 3;
    localparam int OAW = 6;
    localparam int TW  = 8;
    localparam int CW  = 9;
    localparam int RW  = 2;

    logic                 clk = 1'b0;
    logic                 srst;
    logic                 tpu_start;
    logic [TW-1:0]        num_tiles;
    logic [AW-1:0]        tile_len;
    logic [NB*AW-1:0]     sram_raddr_w;
    logic [NB*AW-1:0]     sram_raddr_d;
    logic                 alu_start;
    logic [CW-1:0]        cycle_num;
    logic [RW-1:0]        matrix_index;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [NOB-1:0]       sram_write_enable;
    logic [OAW-1:0]       sram_waddr;
    logic                 busy;
    logic                 tpu_done;
`ifdef TPU_TILE_SEQ_ABORT_EN
    logic                 abort;
    logic                 aborted;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    tpu_tile_sequencer #(
        .ARRAY_SIZE     (A),
        .NUM_BANKS      (NB),
        .ADDR_WIDTH     (AW),
        .NUM_OUT_BANKS  (NOB),
        .OUT_ADDR_WIDTH (OAW),
        .TILE_CNT_WIDTH (TW),
        .CYC_WIDTH      (CW)
    ) dut (
        .clk               (clk),
        .srst              (srst),
        .tpu_start         (tpu_start),
        .num_tiles         (num_tiles),
        .tile_len          (tile_len),
        .sram_raddr_w      (sram_raddr_w),
        .sram_raddr_d      (sram_raddr_d),
        .alu_start         (alu_start),
        .cycle_num         (cycle_num),
        .matrix_index      (matrix_index),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .sram_write_enable (sram_write_enable),
        .sram_waddr        (sram_waddr),
        .busy              (busy),
        .tpu_done          (tpu_done)
`ifdef TPU_TILE_SEQ_ABORT_EN
        ,
        .abort             (abort),
        .aborted           (aborted)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic banksEqual();
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (sram_raddr_w[b*AW +: AW] !== sram_raddr_w[AW-1:0]) ok = 1'b0;
            if (sram_raddr_d[b*AW +: AW] !== sram_raddr_w[AW-1:0]) ok = 1'b0;
        end
        return ok;
    endfunction

    // Read stream entry k of a job: each tile keeps alu_start high for
    // l + 2A - 1 cycles. The address walks t*l .. t*l+l-1 and then holds.
    function automatic logic [31:0] expRead(input int l, input int k);
        int per, t, i, addr, cn;
        per  = l + 2 * A - 1;
        t    = k / per;
        i    = k % per;
        addr = (t * l + ((i < l) ? i : l - 1)) % (1 << AW);
        cn   = i % (1 << CW);
        return 32'((addr << 10) | (cn << 1) | 1);
    endfunction

    // Write stream entry k: tile t goes to bank t%3 in round t/3.
    function automatic logic [31:0] expWrite(input int k);
        int t, r, bank, rnd, wa;
        t    = k / A;
        r    = k % A;
        bank = t % NOB;
        rnd  = t / NOB;
        wa   = (rnd * A + r) % (1 << OAW);
        return 32'(((1 << bank) << 16) | (wa << 8) | r);
    endfunction

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_busy"},     busy, 0);
        checkOutput({pfx, "_done"},     tpu_done, 0);
        checkOutput({pfx, "_alu"},      alu_start, 0);
        checkOutput({pfx, "_wvalid"},   wr_valid, 0);
        checkOutput({pfx, "_raddr_w"},  (sram_raddr_w == '0), 1);
        checkOutput({pfx, "_raddr_d"},  (sram_raddr_d == '0), 1);
        checkOutput({pfx, "_cycnum"},   cycle_num, 0);
        checkOutput({pfx, "_mindex"},   matrix_index, 0);
        checkOutput({pfx, "_waddr"},    sram_waddr, 0);
        checkOutput({pfx, "_we"},       sram_write_enable, 0);
`ifdef TPU_TILE_SEQ_ABORT_EN
        checkOutput({pfx, "_aborted"},  aborted, 0);
`endif
    endtask

    // Run one job from the idle state and check it at transaction level.
    // mode 0: wr_ready held high; 1: random backpressure; 2: three stall
    // cycles on row 2 of the first tile.
    task automatic applyStimulus(input int n, input int l, input int mode);
        logic [31:0] rdObs[$];
        logic [31:0] wrObs[$];
        int  t0, doneCyc, doneCnt, stalls, busyCnt, firstRd, firstWr;
        int  budget, stallLeft, k, expDone, bad, nExp;
        bit  empty, prevActive;
        empty      = (n == 0) || (l == 0);
        doneCyc    = -1;
        doneCnt    = 0;
        stalls     = 0;
        busyCnt    = 0;
        firstRd    = -1;
        firstWr    = -1;
        stallLeft  = 3;
        prevActive = 1'b0;
        budget     = empty ? 20 : n * (l + 3 * A) * 4 + 50;

        @(posedge clk); #1;
        t0        = cyc;
        tpu_start = 1'b1;
        num_tiles = TW'(n);
        tile_len  = AW'(l);
        wr_ready  = 1'b1;
        @(negedge clk);

        k = 0;
        while (k < budget && !(doneCyc >= 0 && cyc >= doneCyc + 2)) begin
            @(posedge clk); #1;
            if (empty && cyc == t0 + 1) tpu_start = 1'b1;
            else if (prevActive)        tpu_start = 1'($urandom_range(0, 1));
            else                        tpu_start = 1'b0;
            num_tiles = TW'($urandom);
            tile_len  = AW'($urandom);
            case (mode)
                1: wr_ready = ($urandom_range(0, 99) < 65);
                2: begin
                    if (wr_valid && matrix_index == 2'd2 && stallLeft > 0) begin
                        wr_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
                default: wr_ready = 1'b1;
            endcase
            @(negedge clk);
            if (busy) busyCnt++;
            if (tpu_done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
`ifdef TPU_TILE_SEQ_ABORT_EN
                checkOutput("normal_aborted", aborted, 0);
`endif
            end
            if (alu_start) begin
                rdObs.push_back({12'b0, sram_raddr_w[AW-1:0], cycle_num, banksEqual()});
                if (firstRd < 0) firstRd = cyc;
            end
            if (sram_write_enable != '0) begin
                wrObs.push_back({13'b0, sram_write_enable, 2'b0, sram_waddr, 6'b0, matrix_index});
                if (firstWr < 0) firstWr = cyc;
            end
            if (wr_valid && !wr_ready) begin
                stalls++;
                checkOutput("stall_no_we", sram_write_enable, 0);
                if (mode == 2) begin
                    checkOutput("stall_mindex", matrix_index, 2);
                    checkOutput("stall_waddr", sram_waddr, 2);
                end
            end
            prevActive = alu_start || wr_valid;
            k++;
        end

        checkOutput("done_seen", (doneCyc >= 0), 1);
        checkOutput("done_pulses", doneCnt, 1);
        checkOutput("idle_after_job", busy, 0);

        if (empty) begin
            checkOutput("empty_done_cycle", doneCyc - t0, 2);
            checkOutput("empty_busy_cycles", busyCnt, 1);
            checkOutput("empty_reads", rdObs.size(), 0);
            checkOutput("empty_writes", wrObs.size(), 0);
        end else begin
            expDone = t0 + n * (l + 3 * A - 1) + 1 + stalls;
            checkOutput("done_cycle", doneCyc, expDone);
            checkOutput("busy_cycles", busyCnt, expDone - t0);
            checkOutput("first_read_cycle", firstRd - t0, 1);
            if (mode == 0) checkOutput("first_write_cycle", firstWr - t0, l + 2 * A);
            if (mode == 2) checkOutput("stall_count", stalls, 3);

            nExp = n * (l + 2 * A - 1);
            checkOutput("read_count", rdObs.size(), nExp);
            bad = -1;
            for (int i = 0; i < rdObs.size() && i < nExp; i++)
                if (bad < 0 && rdObs[i] !== expRead(l, i)) bad = i;
            if (bad < 0) bad = ((rdObs.size() < nExp) ? rdObs.size() : nExp) - 1;
            if (bad >= 0) checkOutput("read_stream", rdObs[bad], expRead(l, bad));

            nExp = n * A;
            checkOutput("write_count", wrObs.size(), nExp);
            bad = -1;
            for (int i = 0; i < wrObs.size() && i < nExp; i++)
                if (bad < 0 && wrObs[i] !== expWrite(i)) bad = i;
            if (bad < 0) bad = ((wrObs.size() < nExp) ? wrObs.size() : nExp) - 1;
            if (bad >= 0) checkOutput("write_stream", wrObs[bad], expWrite(bad));
        end
        tpu_start = 1'b0;
        wr_ready  = 1'b1;
    endtask

    // Reset partway through a job, then expect a clean idle state.
    task automatic applyMidReset(input int l, input int offset, input bit inWrite);
        int t0;
        @(posedge clk); #1;
        t0        = cyc;
        tpu_start = 1'b1;
        num_tiles = TW'(2);
        tile_len  = AW'(l);
        wr_ready  = 1'b1;
        while (cyc < t0 + offset) begin
            @(posedge clk); #1;
            tpu_start = 1'b0;
        end
        srst = 1'b1;
        @(negedge clk);
        if (inWrite) begin
            checkOutput("srst_write_valid", wr_valid, 1);
            checkOutput("srst_write_no_we", sram_write_enable, 0);
        end else begin
            checkOutput("srst_drain_alu", alu_start, 1);
        end
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        checkResetValues(inWrite ? "srst_write" : "srst_drain");
    endtask

`ifdef TPU_TILE_SEQ_ABORT_EN
    task automatic applyAbort();
        bit found;
        found = 1'b0;
        @(posedge clk); #1;
        tpu_start = 1'b1;
        num_tiles = TW'(2);
        tile_len  = AW'(3);
        wr_ready  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            tpu_start = 1'b0;
            if (wr_valid && matrix_index == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("abort_reached_row1", found, 1);
        abort = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_done", tpu_done, 1);
        checkOutput("abort_flag", aborted, 1);
        checkOutput("abort_alu", alu_start, 0);
        checkOutput("abort_wvalid", wr_valid, 0);
        checkOutput("abort_we", sram_write_enable, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("abort_idle_busy", busy, 0);
        checkOutput("abort_flag_clear", aborted, 0);
        checkOutput("abort_done_clear", tpu_done, 0);
        checkOutput("abort_idle_we", sram_write_enable, 0);
    endtask
`endif

    initial begin
        int n, l;
        srst      = 1'b1;
        tpu_start = 1'b0;
        num_tiles = '0;
        tile_len  = '0;
        wr_ready  = 1'b1;
`ifdef TPU_TILE_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk); #1;
        srst = 1'b0;

        $display("[TB] single tile, no backpressure");
        applyStimulus(1, 4, 0);
        $display("[TB] four tiles, bank round robin");
        applyStimulus(4, 4, 0);
        $display("[TB] three stall cycles on row 2");
        applyStimulus(1, 4, 2);
        $display("[TB] empty jobs");
        applyStimulus(0, 5, 0);
        applyStimulus(3, 0, 0);

        $display("[TB] reset mid-drain and mid-write");
        applyMidReset(5, 8, 1'b0);
        applyStimulus(2, 5, 1);
        applyMidReset(2, 11, 1'b1);
        applyStimulus(1, 2, 0);

        $display("[TB] randomized jobs");
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 6);
            l = $urandom_range(1, 12);
            applyStimulus(n, l, 1);
        end
        $display("[TB] address and counter wrap");
        applyStimulus(2, 700, 1);
        applyStimulus(50, 1, 1);

`ifdef TPU_TILE_SEQ_ABORT_EN
        $display("[TB] abort during write");
        applyAbort();
        applyStimulus(1, 3, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
